// File: rtl/disp_vramctrl_pkg.sv
// Shared display package: fetcher states, AXI burst encodings and default frame geometry.
package disp_vramctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_WAIT_BUF,
        ST_ADDR,
        ST_DATA
    } state_t;

    localparam int unsigned AXI_AW = 32;
    localparam int unsigned AXI_DW = 64;

    localparam logic [2:0] SIZE_8B    = 3'b011;
    localparam logic [1:0] BURST_INCR = 2'b01;

    localparam int unsigned DEF_WORDS_PER_FRAME = 153600;
    localparam int unsigned DEF_BURST_LEN       = 16;

    // Clear the low address bits so every burst starts on its own natural boundary.
    function automatic logic [AXI_AW-1:0] align_addr(input logic [AXI_AW-1:0] a,
                                                    input int unsigned bits);
        return a & ~((AXI_AW'(1) << bits) - AXI_AW'(1));
    endfunction

endpackage

// File: rtl/disp_vramctrl_if.sv
// AXI4 read-only channel bundle between the VRAM frame fetcher and the memory side.
interface disp_vramctrl_if;
    import disp_vramctrl_pkg::*;

    logic [AXI_AW-1:0] ARADDR;
    logic [7:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic              ARVALID;
    logic              ARREADY;
    logic [AXI_DW-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;

    modport master (
        output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        input  ARREADY, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        output ARREADY, RDATA, RRESP, RLAST, RVALID
    );

endinterface

// File: rtl/disp_vramctrl.sv
// Frame fetcher: clears the display FIFO on frame start, then streams one frame
// from VRAM with single-outstanding AXI4 INCR bursts straight into the FIFO write port.
module disp_vramctrl
    import disp_vramctrl_pkg::*;
#(
    parameter int unsigned WORDS_PER_FRAME = DEF_WORDS_PER_FRAME,
    parameter int unsigned BURST_LEN       = DEF_BURST_LEN
) (
    input  logic              ACLK,
    input  logic              ARSTN,
    input  logic              DISPON,
    input  logic              VRSTART,
    input  logic [AXI_AW-1:0] DISPADDR,
    input  logic              BUF_WREADY,
    output logic              FIFORST,
    output logic [AXI_DW-1:0] FIFOIN,
    output logic              FIFOWR,
    output logic              RD_ERR,
    output logic              BUSY,
    disp_vramctrl_if.master   axi
);

    localparam int unsigned BURST_BYTES = BURST_LEN * 8;
    localparam int unsigned ALIGN_BITS  = $clog2(BURST_BYTES);
    localparam int unsigned WL_W        = $clog2(WORDS_PER_FRAME + 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AXI_AW-1:0] r_addr;
    logic [AXI_AW-1:0] r_next_addr;
    logic [WL_W-1:0]   r_words_left;
    logic              r_pend;
    logic              r_rd_err;

    logic              w_start;
    logic              w_beat;
    logic              w_last_beat;
    logic              w_frame_done;
    logic              w_load;
    logic [AXI_AW-1:0] w_base;
    logic [AXI_AW-1:0] w_rst_addr;
    logic              w_arvalid;
    logic              w_rready;
    logic              w_fiforst;
    logic              w_busy;

    assign w_start      = VRSTART & DISPON;
    assign w_base       = align_addr(DISPADDR, ALIGN_BITS);
    assign w_beat       = axi.RVALID & w_rready;
    assign w_last_beat  = w_beat & axi.RLAST;
    assign w_frame_done = (r_words_left == WL_W'(BURST_LEN));
    // A restart deferred behind an in-flight burst uses the address captured at the pulse.
    assign w_rst_addr   = w_start ? w_base : r_next_addr;
    assign w_load       = (w_state_nxt == ST_CLR);

    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (w_start) w_state_nxt = ST_CLR;
            ST_CLR:      w_state_nxt = w_start ? ST_CLR : ST_WAIT_BUF;
            ST_WAIT_BUF: begin
                if (w_start)         w_state_nxt = ST_CLR;
                else if (!DISPON)    w_state_nxt = ST_IDLE;
                else if (BUF_WREADY) w_state_nxt = ST_ADDR;
            end
            ST_ADDR:     if (axi.ARREADY) w_state_nxt = ST_DATA;
            ST_DATA: begin
                if (w_last_beat) begin
                    if (r_pend || w_start)          w_state_nxt = ST_CLR;
                    else if (w_frame_done || !DISPON) w_state_nxt = ST_IDLE;
                    else                            w_state_nxt = ST_WAIT_BUF;
                end
            end
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_arvalid = 1'b0;
        w_rready  = 1'b0;
        w_fiforst = 1'b0;
        w_busy    = 1'b1;
        case (r_state)
            ST_IDLE: w_busy    = 1'b0;
            ST_CLR:  w_fiforst = 1'b1;
            ST_ADDR: w_arvalid = 1'b1;
            ST_DATA: w_rready  = 1'b1;
            default: ;
        endcase
    end

    // Burst address, remaining word count, deferred restart and sticky read error.
    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            r_addr       <= '0;
            r_next_addr  <= '0;
            r_words_left <= '0;
            r_pend       <= 1'b0;
            r_rd_err     <= 1'b0;
        end else begin
            if (w_load) begin
                r_addr       <= w_rst_addr;
                r_words_left <= WL_W'(WORDS_PER_FRAME);
                r_pend       <= 1'b0;
            end else begin
                if (w_last_beat) begin
                    r_addr       <= r_addr + AXI_AW'(BURST_BYTES);
                    r_words_left <= r_words_left - WL_W'(BURST_LEN);
                end
                if (w_start) begin
                    r_pend      <= 1'b1;
                    r_next_addr <= w_base;
                end
            end
            if (w_beat && axi.RRESP[1]) r_rd_err <= 1'b1;
            else if (w_start)           r_rd_err <= 1'b0;
        end
    end

    assign axi.ARADDR  = r_addr;
    assign axi.ARLEN   = 8'(BURST_LEN - 1);
    assign axi.ARSIZE  = SIZE_8B;
    assign axi.ARBURST = BURST_INCR;
    assign axi.ARVALID = w_arvalid;
    assign axi.RREADY  = w_rready;
    assign FIFORST     = w_fiforst;
    assign FIFOIN      = axi.RDATA;
    assign FIFOWR      = w_beat;
    assign RD_ERR      = r_rd_err;
    assign BUSY        = w_busy;

endmodule

// File: tb/tb_disp_vramctrl.sv
// Directed bench for disp_vramctrl: table of frame base addresses plus hand-written
// sequences for restart, backpressure, display-off, read error and async reset.
module tb_disp_vramctrl;

    logic        ACLK = 1'b0;
    logic        ARSTN;
    logic        DISPON;
    logic        VRSTART;
    logic [31:0] DISPADDR;
    logic        BUF_WREADY;
    logic        FIFORST;
    logic [63:0] FIFOIN;
    logic        FIFOWR;
    logic        RD_ERR;
    logic        BUSY;

    disp_vramctrl_if axi();

    disp_vramctrl #(
        .WORDS_PER_FRAME(64),
        .BURST_LEN      (16)
    ) dut (
        .ACLK      (ACLK),
        .ARSTN     (ARSTN),
        .DISPON    (DISPON),
        .VRSTART   (VRSTART),
        .DISPADDR  (DISPADDR),
        .BUF_WREADY(BUF_WREADY),
        .FIFORST   (FIFORST),
        .FIFOIN    (FIFOIN),
        .FIFOWR    (FIFOWR),
        .RD_ERR    (RD_ERR),
        .BUSY      (BUSY),
        .axi       (axi)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor / slave bookkeeping, reset per scenario
    logic [31:0] ar_log [16];
    int          ar_n, wr_n, fiforst_n, rst_wr, data_err, ovl_err, gbeat, err_beat;
    logic        ar_ready_en = 1'b1;
    logic        s_active = 1'b0;
    logic [31:0] s_base = '0;
    int          s_beat = 0;

    function automatic logic [63:0] mem(input logic [31:0] a);
        return {a ^ 32'hA5A5_5A5A, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        ar_n = 0; wr_n = 0; fiforst_n = 0; rst_wr = 0;
        data_err = 0; ovl_err = 0; gbeat = 0; err_beat = -1;
    endtask

    task automatic pulse_vrstart();
        @(posedge ACLK); #1 VRSTART = 1'b1;
        @(posedge ACLK); #1 VRSTART = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (BUSY && n < 2000) begin @(negedge ACLK); n++; end
        check(name, BUSY, 0);
    endtask

    task automatic wait_writes(input int target);
        int n = 0;
        while (wr_n < target && n < 1000) begin @(posedge ACLK); n++; end
        check("wait_writes", 64'(wr_n >= target), 1);
    endtask

    // Memory slave and monitor: observe at negedge, drive just after posedge
    initial begin
        axi.ARREADY = 1'b0; axi.RVALID = 1'b0; axi.RLAST = 1'b0;
        axi.RDATA = '0; axi.RRESP = 2'b00;
        forever begin
            @(negedge ACLK);
            if (!ARSTN) begin
                s_active = 1'b0;
            end else begin
                if (FIFORST) begin fiforst_n++; rst_wr = wr_n; end
                if (axi.ARVALID) begin
                    if (s_active) ovl_err++;
                    if (axi.ARREADY) begin
                        if (ar_n < 16) ar_log[ar_n] = axi.ARADDR;
                        ar_n++;
                        s_base = axi.ARADDR; s_beat = 0; s_active = 1'b1;
                    end
                end
                if (FIFOWR !== (axi.RVALID & axi.RREADY)) data_err++;
                if (FIFOWR) begin
                    wr_n++;
                    if (FIFOIN !== mem(s_base + 32'(s_beat * 8))) data_err++;
                end
                if (axi.RVALID && axi.RREADY) begin
                    if (axi.RLAST) s_active = 1'b0;
                    s_beat++; gbeat++;
                end
            end
            @(posedge ACLK); #1;
            axi.ARREADY = ar_ready_en;
            axi.RVALID  = s_active;
            axi.RDATA   = mem(s_base + 32'(s_beat * 8));
            axi.RLAST   = (s_beat == 15);
            axi.RRESP   = (gbeat == err_beat) ? 2'b10 : 2'b00;
        end
    end

    typedef struct {
        logic [31:0] base;
        logic [31:0] exp_ar0;
        logic [31:0] exp_ar1;
        logic [31:0] exp_ar3;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int cnt;
        vecs[0] = '{32'h2000_0000, 32'h2000_0000, 32'h2000_0080, 32'h2000_0180};
        vecs[1] = '{32'h2000_0044, 32'h2000_0000, 32'h2000_0080, 32'h2000_0180};
        vecs[2] = '{32'hFFFF_FF80, 32'hFFFF_FF80, 32'h0000_0000, 32'h0000_0100};
        vecs[3] = '{32'h1234_56FF, 32'h1234_5680, 32'h1234_5700, 32'h1234_5800};

        ARSTN = 1'b0; DISPON = 1'b1; VRSTART = 1'b0;
        DISPADDR = 32'h2000_0000; BUF_WREADY = 1'b1;
        clear_logs();
        repeat (3) @(negedge ACLK);
        check("rst_ctrl", {axi.ARVALID, axi.RREADY, FIFORST, FIFOWR, RD_ERR, BUSY}, 0);
        check("rst_araddr", axi.ARADDR, 0);
        check("arlen", axi.ARLEN, 15);
        check("arsize", axi.ARSIZE, 3);
        check("arburst", axi.ARBURST, 1);
        @(posedge ACLK); #1 ARSTN = 1'b1;
        repeat (2) @(posedge ACLK);

        // Start latency: FIFORST at t+1, earliest ARVALID at t+3
        clear_logs();
        pulse_vrstart();
        @(negedge ACLK);
        check("t1_fiforst_busy", {FIFORST, BUSY, axi.ARVALID}, 3'b110);
        @(negedge ACLK);
        check("t2_fiforst_arv", {FIFORST, axi.ARVALID}, 2'b00);
        @(negedge ACLK);
        check("t3_arvalid", axi.ARVALID, 1);
        check("t3_araddr", axi.ARADDR, 32'h2000_0000);
        wait_idle("t_frame_end");
        check("t_writes", wr_n, 64);

        for (int i = 0; i < 4; i++) begin
            clear_logs();
            DISPADDR = vecs[i].base;
            pulse_vrstart();
            wait_idle("v_frame_end");
            check("v_nar", ar_n, 4);
            check("v_ar0", ar_log[0], vecs[i].exp_ar0);
            check("v_ar1", ar_log[1], vecs[i].exp_ar1);
            check("v_ar3", ar_log[3], vecs[i].exp_ar3);
            check("v_writes", wr_n, 64);
            check("v_fiforst", fiforst_n, 1);
            check("v_data_err", data_err, 0);
            check("v_overlap", ovl_err, 0);
        end

        // VRSTART with display off is ignored
        DISPON = 1'b0; clear_logs();
        pulse_vrstart();
        repeat (5) @(negedge ACLK);
        check("off_busy", BUSY, 0);
        check("off_fiforst", fiforst_n, 0);
        DISPON = 1'b1;

        // Backpressure after the first burst
        clear_logs(); DISPADDR = 32'h2000_0000;
        pulse_vrstart();
        wait_writes(16);
        #1 BUF_WREADY = 1'b0;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (axi.ARVALID) cnt++;
        end
        check("bp_no_arvalid", cnt, 0);
        @(posedge ACLK); #1 BUF_WREADY = 1'b1;
        @(negedge ACLK);
        @(negedge ACLK);
        check("bp_resume", axi.ARVALID, 1);
        wait_idle("bp_frame_end");
        check("bp_nar", ar_n, 4);
        check("bp_writes", wr_n, 64);

        // Restart in the middle of the second burst
        clear_logs();
        pulse_vrstart();
        wait_writes(20);
        #1 VRSTART = 1'b1;
        @(posedge ACLK); #1 VRSTART = 1'b0;
        wait_idle("rs_frame_end");
        check("rs_fiforst", fiforst_n, 2);
        check("rs_wr_at_clr", rst_wr, 32);
        check("rs_writes", wr_n, 96);
        check("rs_nar", ar_n, 6);
        check("rs_ar2_base", ar_log[2], 32'h2000_0000);
        check("rs_ar5", ar_log[5], 32'h2000_0180);
        check("rs_data_err", data_err, 0);

        // Display off while the address phase is stalled
        clear_logs(); ar_ready_en = 1'b0;
        pulse_vrstart();
        cnt = 0;
        while (!axi.ARVALID && cnt < 100) begin @(negedge ACLK); cnt++; end
        @(posedge ACLK); #1 DISPON = 1'b0;
        repeat (3) @(posedge ACLK);
        #1 ar_ready_en = 1'b1;
        wait_idle("do_frame_end");
        repeat (20) @(negedge ACLK);
        check("do_nar", ar_n, 1);
        check("do_writes", wr_n, 16);
        check("do_busy", BUSY, 0);
        DISPON = 1'b1;

        // Read error is sticky, cleared by the next frame start
        clear_logs(); err_beat = 5;
        pulse_vrstart();
        wait_idle("er_frame_end");
        check("er_set", RD_ERR, 1);
        repeat (10) @(negedge ACLK);
        check("er_hold", RD_ERR, 1);
        clear_logs();
        pulse_vrstart();
        @(negedge ACLK);
        check("er_clear", RD_ERR, 0);
        wait_idle("er2_frame_end");

        // Asynchronous reset mid-burst
        clear_logs(); err_beat = 2;
        pulse_vrstart();
        wait_writes(8);
        #1 check("ar_err_before", RD_ERR, 1);
        #2 ARSTN = 1'b0;
        #1 check("ar_outputs", {axi.ARVALID, axi.RREADY, FIFORST, FIFOWR, RD_ERR, BUSY}, 0);
        check("ar_araddr", axi.ARADDR, 0);
        repeat (3) @(posedge ACLK);
        #1 ARSTN = 1'b1;
        repeat (10) @(negedge ACLK);
        check("ar_idle", {BUSY, axi.ARVALID, FIFORST}, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/disp_vramctrl.md
# disp_vramctrl

Frame fetcher feeding the display FIFO from the AXI side. On each frame-start pulse it clears the FIFO, then streams one frame from VRAM with single-outstanding AXI4 INCR read bursts. Each 64-bit read beat is pushed straight into the display buffer's write port (FIFOIN/FIFOWR). New bursts are issued only while the buffer reports room (BUF_WREADY). It is the writer end of the FIFO that the display-clock buffer drains.

## Interface
- WORDS_PER_FRAME, 153600: 64-bit words per frame (640x480 pixels at 2 pixels/word); must be a multiple of BURST_LEN
- BURST_LEN, 16: beats per burst, range 1..256
- ACLK  in  1  system clock; the only clock
- ARSTN  in  1  asynchronous, active-low reset
- DISPON  in  1  display enable; fetching is allowed only while 1
- VRSTART  in  1  one-cycle frame-start pulse, already synchronous to ACLK
- DISPADDR  in  32  frame base byte address; bits [log2(BURST_LEN*8)-1:0] ignored (treated as 0)
- BUF_WREADY  in  1  display buffer has at least 256 free entries
- FIFORST  out  1  one-cycle FIFO clear
- FIFOIN  out  64  write data (= RDATA)
- FIFOWR  out  1  write strobe (= RVALID & RREADY)
- ARADDR  out  32  burst start address
- ARLEN  out  8  constant BURST_LEN-1
- ARSIZE  out  3  constant 3'b011
- ARBURST  out  2  constant 2'b01
- ARVALID  out  1  / ARREADY  in  1  read-address handshake
- RDATA  in  64, RRESP  in  2, RLAST  in  1, RVALID  in  1  read-data channel
- RREADY  out  1  read-data ready
- RD_ERR  out  1  sticky; set on any beat with RRESP[1]=1; cleared by reset or VRSTART
- BUSY  out  1  frame fetch in progress (state != IDLE)

## Operation
- States: IDLE, CLR, WAIT_BUF, ADDR, DATA.
- IDLE: on VRSTART & DISPON, latch the aligned DISPADDR into the address register, load words_left = WORDS_PER_FRAME, go to CLR.
- CLR: FIFORST=1 for exactly one cycle, then go to WAIT_BUF.
- WAIT_BUF: if !DISPON, go to IDLE. Otherwise, when BUF_WREADY=1, go to ADDR.
- ADDR: ARVALID=1 with ARADDR held stable until ARREADY. On the handshake go to DATA.
- DATA: RREADY=1. Every beat accepted produces FIFOWR=1 and FIFOIN=RDATA in the same cycle.
- On the beat with RLAST: address += BURST_LEN*8 (32-bit wrap), words_left -= BURST_LEN.
  - If pending restart is set, go to CLR with the new address.
  - Else if words_left reaches 0 or !DISPON, go to IDLE.
  - Else go to WAIT_BUF.
- RLAST is trusted. Beat count is not checked against it.
- VRSTART arriving in WAIT_BUF or CLR restarts immediately: relatch address and count, go to CLR.
- VRSTART arriving in ADDR or DATA sets pending restart. The in-flight burst always completes, because AXI bursts cannot be aborted; its beats are still written and then cleared by the following CLR.
- VRSTART with DISPON=0 is ignored.
- DISPON falling during ADDR or DATA: the current burst completes, then the block returns to IDLE.
- Bursts never cross a 4 KB boundary, because the base is burst-aligned and the burst size is ≤ 2 KB.

## Timing
- All outputs return to 0 in reset: ARVALID, RREADY, FIFORST, FIFOWR, RD_ERR, BUSY, ARADDR. ARLEN, ARSIZE and ARBURST are constants.
- VRSTART sampled at edge t: FIFORST is high during cycle t+1 and BUSY is high from t+1. The earliest ARVALID is cycle t+3, if BUF_WREADY is already 1.
- ARVALID rises at most 1 cycle after BUF_WREADY is seen in WAIT_BUF.
- At most one outstanding burst at any time. The next ARVALID comes no earlier than 2 cycles after RLAST.
- FIFOWR has zero latency from the R handshake. FIFOIN is a combinational path from RDATA.
- Only the first burst of a frame is limited by CLR. Between bursts the only stall source is BUF_WREADY.

## Structure
- The shared display package holds the state enum, the AXI constants (SIZE_8B, BURST_INCR) and the default frame geometry constants.
- Single module, no sub-modules. Address and word counters are local registers; words_left is $clog2(WORDS_PER_FRAME+1) bits wide.

## Test plan
- Nominal frame (WORDS_PER_FRAME=64, BURST_LEN=16, DISPADDR=0x2000_0000, ARREADY and RVALID always 1, BUF_WREADY=1): FIFORST is pulsed once. Exactly 4 ARs at 0x2000_0000/080/100/180, 64 FIFOWR pulses with data equal to the memory model, then BUSY drops.
- Backpressure: BUF_WREADY is forced to 0 after the first burst for 50 cycles. No ARVALID appears in that window, and fetching resumes within 1 cycle of release.
- Unaligned base DISPADDR=0x2000_0044: first ARADDR is 0x2000_0000.
- VRSTART in the middle of the second burst: that burst completes all 16 beats, then FIFORST is pulsed, then ARADDR restarts at base and 64 further writes follow.
- DISPON drops during ADDR: the handshake and burst complete, then the block goes to IDLE with no further AR.
- Error and reset: one beat has RRESP=2'b10, and RD_ERR sets and holds. Asserting ARSTN low mid-burst clears all outputs immediately, and the block sits in IDLE after release.
